// File: rtl/prescaled_updown_counter.sv
// -----------------------------------------------------------------------------
// prescaled_updown_counter
//
// A WIDTH-bit up/down counter that drives the LED bank. It advances once per
// prescaler period (every DIV enabled clocks) and once per rising edge of a
// push button. It can wrap or saturate at its limits, and it supports a
// synchronous clear and a synchronous load. o_tick and o_tc are registered
// pulses that let a second stage be cascaded onto this one.
//
// Parameters:
//   WIDTH    - counter/LEDR width in bits (1..32)
//   DIV      - prescaler period in clocks (>= 2)
//   SATURATE - 0: wrap at the limits, 1: hold at the limits
//
// Ports:
//   i_clk       in   system clock, rising edge
//   i_rst       in   asynchronous reset, active-high
//   i_en        in   prescaler run enable (0 pauses it without losing phase)
//   i_dir       in   0 = count up, 1 = count down (sampled on the step edge)
//   i_step      in   asynchronous button; each rising edge requests one step
//   i_load      in   synchronous load strobe
//   i_load_val  in   value loaded on i_load
//   i_clr       in   synchronous clear strobe (wins over i_load)
//   LEDR        out  registered count value
//   o_tick      out  one-cycle pulse in the cycle LEDR shows a step result
//   o_tc        out  one-cycle pulse when a step hit a limit
// -----------------------------------------------------------------------------
module prescaled_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int DIV      = 50000000,
  parameter int SATURATE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_step,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_clr,
  output logic [WIDTH-1:0] LEDR,
  output logic             o_tick,
  output logic             o_tc
);

  localparam int               PW       = $clog2(DIV);
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_MIN  = '0;

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             s1_q, s2_q, s3_q;

  logic ptick;
  logic spulse;
  logic step_evt;

  // The prescaler ends its period only while it is enabled, so pausing it
  // with i_en keeps the current phase.
  assign ptick    = i_en && (presc_q == PRE_LAST);

  // s1 is the metastability catcher. The edge is detected between s2 and s3,
  // so a held button gives one pulse only.
  assign spulse   = s2_q & ~s3_q;

  // A button step that lands on a prescaler tick merges with it: one step.
  assign step_evt = ptick | spulse;

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    presc_d = presc_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;

    if (i_en) begin
      presc_d = ptick ? '0 : presc_q + PW'(1);
    end

    if (i_clr) begin
      cnt_d   = '0;
      presc_d = '0;
    end else if (i_load) begin
      // Restarting the prescaler puts the next tick a full period after the load.
      cnt_d   = i_load_val;
      presc_d = '0;
    end else if (step_evt) begin
      tick_d = 1'b1;
      if (!i_dir) begin
        if (cnt_q == CNT_MAX) begin
          tc_d  = 1'b1;
          cnt_d = (SATURATE != 0) ? CNT_MAX : CNT_MIN;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == CNT_MIN) begin
          tc_d  = 1'b1;
          cnt_d = (SATURATE != 0) ? CNT_MIN : CNT_MAX;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments, so every
  // flop samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
      // The synchroniser keeps shifting during clear/load. An edge that is
      // dropped there is not replayed later.
      s1_q    <= i_step;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  assign LEDR   = cnt_q;
  assign o_tick = tick_q;
  assign o_tc   = tc_q;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// -----------------------------------------------------------------------------
// Directed testbench for prescaled_updown_counter. Two instances share one
// set of inputs: one wraps at the limits (SATURATE=0) and one holds there
// (SATURATE=1). Both use WIDTH=4 and DIV=4.
// -----------------------------------------------------------------------------
module tb_prescaled_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dir;
  logic       step;
  logic       load;
  logic [3:0] load_val;
  logic       clr;

  logic [3:0] ledr_w, ledr_s;
  logic       tick_w, tick_s;
  logic       tc_w, tc_s;

  int checks = 0;
  int errors = 0;

  prescaled_updown_counter #(.WIDTH(4), .DIV(4), .SATURATE(0)) dut_wrap (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_dir      (dir),
    .i_step     (step),
    .i_load     (load),
    .i_load_val (load_val),
    .i_clr      (clr),
    .LEDR       (ledr_w),
    .o_tick     (tick_w),
    .o_tc       (tc_w)
  );

  prescaled_updown_counter #(.WIDTH(4), .DIV(4), .SATURATE(1)) dut_sat (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_dir      (dir),
    .i_step     (step),
    .i_load     (load),
    .i_load_val (load_val),
    .i_clr      (clr),
    .LEDR       (ledr_s),
    .o_tick     (tick_s),
    .o_tc       (tc_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    dir      = 1'b0;
    step     = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    clr      = 1'b0;

    // ---------------- Reset state ----------------
    #2;
    check("reset ledr", 32'(ledr_w), 32'd0);
    check("reset tick", 32'(tick_w), 32'd0);
    check("reset tc",   32'(tc_w),   32'd0);

    // ---------------- Test 1: free-running count up, wrap ----------------
    // Release reset between edges. The prescaler reads 1,2,3 after edges 1..3,
    // so the counter steps on every 4th edge.
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      cycles(1);
      check($sformatf("t1 tick e%0d", n), 32'(tick_w), (n % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("t1 ledr e%0d", n), 32'(ledr_w), 32'((n / 4) % 16));
      check($sformatf("t1 tc e%0d", n),   32'(tc_w),   (n == 64) ? 32'd1 : 32'd0);
    end

    // ---------------- Test 2: count down from 1, saturate vs wrap ----------
    load     = 1'b1;
    load_val = 4'd1;
    dir      = 1'b1;
    cycles(1);                       // load edge L
    load = 1'b0;
    check("t2 load sat ledr", 32'(ledr_s), 32'd1);
    check("t2 load tick",     32'(tick_s), 32'd0);
    cycles(3);                       // L+3
    check("t2 pre tick",      32'(tick_s), 32'd0);
    cycles(1);                       // L+4: 1 -> 0
    check("t2 tick1 ledr",    32'(ledr_s), 32'd0);
    check("t2 tick1 tick",    32'(tick_s), 32'd1);
    check("t2 tick1 tc",      32'(tc_s),   32'd0);
    check("t2 wrap tick1 ledr", 32'(ledr_w), 32'd0);
    cycles(4);                       // L+8: hold at 0
    check("t2 tick2 ledr",    32'(ledr_s), 32'd0);
    check("t2 tick2 tick",    32'(tick_s), 32'd1);
    check("t2 tick2 tc",      32'(tc_s),   32'd1);
    check("t2 wrap tick2 ledr", 32'(ledr_w), 32'd15);
    check("t2 wrap tick2 tc",   32'(tc_w),   32'd1);
    cycles(1);                       // L+9: pulses are one cycle long
    check("t2 tc width",      32'(tc_s),   32'd0);
    cycles(3);                       // L+12
    check("t2 tick3 ledr",    32'(ledr_s), 32'd0);
    check("t2 tick3 tick",    32'(tick_s), 32'd1);
    check("t2 tick3 tc",      32'(tc_s),   32'd1);

    // ---------------- Test 3: manual step with the prescaler stopped -------
    en  = 1'b0;
    dir = 1'b0;
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    check("t3 clr ledr", 32'(ledr_w), 32'd0);
    step = 1'b1;                     // held from before edge k
    cycles(1);                       // k: s1 = 1
    check("t3 k ledr",    32'(ledr_w), 32'd0);
    cycles(1);                       // k+1
    check("t3 k1 ledr",   32'(ledr_w), 32'd0);
    check("t3 k1 tick",   32'(tick_w), 32'd0);
    cycles(1);                       // k+2: one step
    check("t3 k2 ledr",   32'(ledr_w), 32'd1);
    check("t3 k2 tick",   32'(tick_w), 32'd1);
    for (int n = 3; n <= 9; n++) begin
      cycles(1);
      check($sformatf("t3 hold ledr k%0d", n), 32'(ledr_w), 32'd1);
      check($sformatf("t3 hold tick k%0d", n), 32'(tick_w), 32'd0);
    end
    step = 1'b0;
    cycles(4);
    check("t3 release ledr", 32'(ledr_w), 32'd1);
    step = 1'b1;
    cycles(3);
    check("t3 second ledr", 32'(ledr_w), 32'd2);
    check("t3 second tick", 32'(tick_w), 32'd1);
    check("t3 second sat",  32'(ledr_s), 32'd2);
    step = 1'b0;
    cycles(4);

    // ---------------- Test 4: clear beats load, then load alone ------------
    en       = 1'b1;
    load     = 1'b1;
    load_val = 4'd9;
    clr      = 1'b1;
    cycles(1);                       // A
    clr = 1'b0;
    check("t4 clr wins", 32'(ledr_w), 32'd0);
    cycles(1);                       // B: load alone
    load = 1'b0;
    check("t4 load ledr", 32'(ledr_w), 32'd9);
    check("t4 load tick", 32'(tick_w), 32'd0);
    cycles(3);                       // B+3
    check("t4 b3 tick",   32'(tick_w), 32'd0);
    check("t4 b3 ledr",   32'(ledr_w), 32'd9);
    cycles(1);                       // B+4
    check("t4 b4 tick",   32'(tick_w), 32'd1);
    check("t4 b4 ledr",   32'(ledr_w), 32'd10);

    // ---------------- Test 5: button pulse coincides with a tick -----------
    // The next ptick is before edge B+8. The button is raised after B+5, so it
    // is sampled at B+6 and spulse is also high before B+8.
    cycles(1);                       // B+5
    step = 1'b1;
    cycles(2);                       // B+7
    check("t5 b7 ledr", 32'(ledr_w), 32'd10);
    check("t5 b7 tick", 32'(tick_w), 32'd0);
    cycles(1);                       // B+8: single step
    check("t5 b8 ledr", 32'(ledr_w), 32'd11);
    check("t5 b8 tick", 32'(tick_w), 32'd1);
    cycles(1);                       // B+9: nothing extra
    check("t5 b9 ledr", 32'(ledr_w), 32'd11);
    check("t5 b9 tick", 32'(tick_w), 32'd0);
    step = 1'b0;

    // ---------------- Test 6: async reset between edges --------------------
    en       = 1'b0;
    load     = 1'b1;
    load_val = 4'd5;
    cycles(1);
    load = 1'b0;
    check("t6 preload", 32'(ledr_w), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("t6 async ledr", 32'(ledr_w), 32'd0);
    check("t6 async tick", 32'(tick_w), 32'd0);
    check("t6 async tc",   32'(tc_w),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    dir = 1'b0;
    cycles(3);
    check("t6 e3 ledr", 32'(ledr_w), 32'd0);
    check("t6 e3 tick", 32'(tick_w), 32'd0);
    cycles(1);
    check("t6 e4 ledr", 32'(ledr_w), 32'd1);
    check("t6 e4 tick", 32'(tick_w), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
